// File: rtl/fifo_sync_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared width helpers and the error-flag type for the
//               parametrised single-clock FIFO.
//                 ptr_width(depth)   - address/pointer width, clog2(depth)
//                 count_width(depth) - occupancy width, clog2(depth)+1, so
//                                      that a count of DEPTH can be held
//                 fifo_err_t         - sticky {overflow, underflow} flags
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage
`default_nettype wire

// File: rtl/fifo_sync_param_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_if
// Description : Write/read handshake bundle of the parametrised FIFO.
//               master : producer/consumer side (drives wr_en, wr_data,
//                        rd_en, clr_err; observes data, status and errors)
//               slave  : FIFO side (the mirror image)
//               Status/data signals: rd_data, rd_valid, full, empty,
//               almost_full, almost_empty, count, overflow, underflow.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);

  localparam int CW = count_width(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/fifo_sync_param_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : Simple dual-port RAM, DEPTH x DATA_WIDTH, one write port and
//               one registered read port.
//   clk, rst          - clock / synchronous reset (clears read register only)
//   wr_en, wr_addr,
//   wr_data           - write port
//   rd_en, rd_addr    - read port; rd_data updates only when rd_en is high
//   rd_data           - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = ptr_width(DEPTH)
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  wr_en,
  input  wire logic [AW-1:0]         wr_addr,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  input  wire logic                  rd_en,
  input  wire logic [AW-1:0]         rd_addr,
  output logic      [DATA_WIDTH-1:0] rd_data
);

  // Storage is intentionally not reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Parametrised single-clock FIFO controller. Holds pointers,
//               explicit occupancy counter, registered status flags and
//               sticky error flags; storage lives in fifo_mem.
//   clk  - clock, all logic on the rising edge
//   rst  - synchronous active-high reset
//   bus  - fifo_if slave port (write/read requests, data, status, errors)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input wire logic clk,
  input wire logic rst,
  fifo_if.slave    bus
);

  localparam int            PW      = ptr_width(DEPTH);
  localparam int            CW      = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_chk_width
      $error("fifo_sync_param: DATA_WIDTH must be >= 1");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_chk_levels
      $error("fifo_sync_param: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end
  endgenerate

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic                  rd_acc;
  logic                  wr_acc;
  fifo_err_t             err;
  fifo_err_t             err_next;
  logic                  full_q;
  logic                  empty_q;
  logic                  afull_q;
  logic                  aempty_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Accept decisions use only registered flags, so no output depends
  // combinationally on wr_en/rd_en. A write into a full FIFO is allowed
  // when a read frees a slot on the same edge.
  assign rd_acc = bus.rd_en & ~empty_q;
  assign wr_acc = bus.wr_en & (~full_q | rd_acc);

  always_comb begin
    cnt_next = cnt;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  // Set wins over clear when both happen on the same edge.
  always_comb begin
    err_next = err;
    if (bus.clr_err) begin
      err_next = '0;
    end
    if (bus.wr_en && !wr_acc) begin
      err_next.overflow = 1'b1;
    end
    if (bus.rd_en && !rd_acc) begin
      err_next.underflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
      err        <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PW'(1);
      end
      if (rd_acc) begin
        rptr <= rptr + PW'(1);
      end
      cnt        <= cnt_next;
      // Flags come from the next-state count so they line up with count.
      full_q     <= (cnt_next == DEPTH_C);
      empty_q    <= (cnt_next == '0);
      afull_q    <= (cnt_next >= AF_C);
      aempty_q   <= (cnt_next <= AE_C);
      rd_valid_q <= rd_acc;
      err        <= err_next;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc & ~rst),
    .wr_addr (wptr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_acc & ~rst),
    .rd_addr (rptr),
    .rd_data (mem_rd_data)
  );

  assign bus.rd_data      = mem_rd_data;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = cnt;
  assign bus.overflow     = err.overflow;
  assign bus.underflow    = err.underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_param
// Description : Self-checking bench for fifo_sync_param (8 bit x 16 entries,
//               AF=14, AE=2). A queue-based model tracks contents, sticky
//               errors and the read register; every output is compared after
//               each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fifo_sync_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  string       phase    = "init";

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ov    = 1'b0;
  logic          m_un    = 1'b0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                      input logic ce, input logic rs);
    logic rd_ok;
    logic wr_ok;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.clr_err = ce;
    rst         = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_ov    = 1'b0;
      m_un    = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
    end else begin
      rd_ok = re && (q.size() > 0);
      wr_ok = we && ((q.size() < DEPTH) || rd_ok);
      if (ce) begin
        m_ov = 1'b0;
        m_un = 1'b0;
      end
      if (we && !wr_ok) m_ov = 1'b1;
      if (re && !rd_ok) m_un = 1'b1;
      if (rd_ok) begin
        m_data  = q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (wr_ok) q.push_back(wd);
    end
    #1;
    check_val("count",        32'(bus.count),        32'(q.size()));
    check_val("empty",        32'(bus.empty),        32'(q.size() == 0));
    check_val("full",         32'(bus.full),         32'(q.size() == DEPTH));
    check_val("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF));
    check_val("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
    check_val("rd_valid",     32'(bus.rd_valid),     32'(m_valid));
    check_val("rd_data",      32'(bus.rd_data),      32'(m_data));
    check_val("overflow",     32'(bus.overflow),     32'(m_ov));
    check_val("underflow",    32'(bus.underflow),    32'(m_un));
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;

    phase = "reset";
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    phase = "fill";
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);

    phase = "overflow";
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    phase = "full_wr_rd";
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);

    phase = "drain";
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    phase = "empty_wr_rd";
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    phase = "wrap";
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
